// File: rtl/issue_queue_if.sv
// Dispatch, forwarding and issue signals between the rename stage, the result
// buses and the integer issue queue.
interface issue_queue_if;
  logic         write_enable;
  logic [5:0]   phys_rd;
  logic [5:0]   phys_rs1;
  logic [5:0]   phys_rs2;
  logic [31:0]  phys_rs1_val;
  logic [31:0]  phys_rs2_val;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [6:0]   opcode;
  logic [31:0]  immediate;
  logic [5:0]   ROB_entry_index;
  logic         fwd_enable;
  logic [5:0]   fwd_rd_funct_unit0;
  logic [5:0]   fwd_rd_funct_unit1;
  logic [5:0]   fwd_rd_funct_unit2;
  logic [5:0]   fwd_rd_mem;
  logic [31:0]  fwd_rd_val_funct_unit0;
  logic [31:0]  fwd_rd_val_funct_unit1;
  logic [31:0]  fwd_rd_val_funct_unit2;
  logic [31:0]  fwd_rd_val_mem;
  logic [138:0] issued_funct_unit0;
  logic [138:0] issued_funct_unit1;
  logic [138:0] issued_funct_unit2;
  logic         funct0_enable;
  logic         funct1_enable;
  logic         funct2_enable;
  logic         issue_queue_full;

  modport master (
    output write_enable, phys_rd, phys_rs1, phys_rs2, phys_rs1_val, phys_rs2_val,
           funct3, funct7, opcode, immediate, ROB_entry_index,
           fwd_enable, fwd_rd_funct_unit0, fwd_rd_funct_unit1, fwd_rd_funct_unit2, fwd_rd_mem,
           fwd_rd_val_funct_unit0, fwd_rd_val_funct_unit1, fwd_rd_val_funct_unit2, fwd_rd_val_mem,
    input  issued_funct_unit0, issued_funct_unit1, issued_funct_unit2,
           funct0_enable, funct1_enable, funct2_enable, issue_queue_full
  );

  modport slave (
    input  write_enable, phys_rd, phys_rs1, phys_rs2, phys_rs1_val, phys_rs2_val,
           funct3, funct7, opcode, immediate, ROB_entry_index,
           fwd_enable, fwd_rd_funct_unit0, fwd_rd_funct_unit1, fwd_rd_funct_unit2, fwd_rd_mem,
           fwd_rd_val_funct_unit0, fwd_rd_val_funct_unit1, fwd_rd_val_funct_unit2, fwd_rd_val_mem,
    output issued_funct_unit0, issued_funct_unit1, issued_funct_unit2,
           funct0_enable, funct1_enable, funct2_enable, issue_queue_full
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order integer issue queue: captures operands from four forwarding buses
// and issues up to three operand-ready instructions per cycle, lowest slot first.
module issue_queue #(
  parameter int DEPTH = 16
) (
  input logic          clk,
  input logic          reset_n,
  issue_queue_if.slave iq
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_r, rs1_rdy_r, rs2_rdy_r;
  logic [5:0]       rd_r      [DEPTH];
  logic [5:0]       rs1_r     [DEPTH];
  logic [5:0]       rs2_r     [DEPTH];
  logic [31:0]      rs1_val_r [DEPTH];
  logic [31:0]      rs2_val_r [DEPTH];
  logic [54:0]      ctl_r     [DEPTH];
  logic [63:0]      ready_tbl_r;
  logic [CW-1:0]    count_r;
  logic [138:0]     pkt_r [3];
  logic [2:0]       en_r;
  logic             full_r;

  logic [32:0]      m1_s [DEPTH];
  logic [32:0]      m2_s [DEPTH];
  logic [DEPTH-1:0] wake1_s, wake2_s, rdy_s, issue_s;
  logic             disp_s;
  logic [IW-1:0]    free_idx_s;
  logic [32:0]      d1_s, d2_s;
  logic [IW-1:0]    sel_idx_s [3];
  logic [2:0]       sel_vld_s;
  logic [1:0]       n_sel_s;
  logic [CW-1:0]    count_next_s;

  // {hit, value} for a tag; buses are prioritised FU0 > FU1 > FU2 > mem.
  function automatic logic [32:0] fwd_lookup(input logic [5:0] tag);
    logic [32:0] res;
    if (!iq.fwd_enable || tag == 6'd0) res = 33'd0;
    else if (iq.fwd_rd_funct_unit0 == tag) res = {1'b1, iq.fwd_rd_val_funct_unit0};
    else if (iq.fwd_rd_funct_unit1 == tag) res = {1'b1, iq.fwd_rd_val_funct_unit1};
    else if (iq.fwd_rd_funct_unit2 == tag) res = {1'b1, iq.fwd_rd_val_funct_unit2};
    else if (iq.fwd_rd_mem == tag)         res = {1'b1, iq.fwd_rd_val_mem};
    else res = 33'd0;
    return res;
  endfunction

  function automatic logic [32:0] resolve(input logic [5:0] tag, input logic [31:0] rf_val,
                                          input logic [32:0] fwd, input logic sb_ready);
    logic [32:0] res;
    if (tag == 6'd0) res = {1'b1, 32'd0};
    else if (fwd[32]) res = {1'b1, fwd[31:0]};
    else if (sb_ready) res = {1'b1, rf_val};
    else res = {1'b0, rf_val};
    return res;
  endfunction

  // Forward matches for every queued source, used for wakeup.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      m1_s[i]    = fwd_lookup(rs1_r[i]);
      m2_s[i]    = fwd_lookup(rs2_r[i]);
      wake1_s[i] = valid_r[i] && !rs1_rdy_r[i] && m1_s[i][32];
      wake2_s[i] = valid_r[i] && !rs2_rdy_r[i] && m2_s[i][32];
    end
  end

  // Dispatch slot choice and source operand resolution.
  always_comb begin
    free_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_r[i]) free_idx_s = IW'(i);
      else free_idx_s = free_idx_s;
    end
    disp_s = iq.write_enable && (count_r != CW'(DEPTH));
    d1_s   = resolve(iq.phys_rs1, iq.phys_rs1_val, fwd_lookup(iq.phys_rs1), ready_tbl_r[iq.phys_rs1]);
    d2_s   = resolve(iq.phys_rs2, iq.phys_rs2_val, fwd_lookup(iq.phys_rs2), ready_tbl_r[iq.phys_rs2]);
  end

  // Select the three lowest-index ready entries, in FU0, FU1, FU2 order.
  always_comb begin
    rdy_s     = valid_r & rs1_rdy_r & rs2_rdy_r;
    issue_s   = '0;
    sel_vld_s = 3'b000;
    n_sel_s   = 2'd0;
    for (int f = 0; f < 3; f++) sel_idx_s[f] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_s[i] && n_sel_s != 2'd3) begin
        sel_idx_s[n_sel_s] = IW'(i);
        sel_vld_s[n_sel_s] = 1'b1;
        issue_s[i]         = 1'b1;
        n_sel_s            = n_sel_s + 2'd1;
      end else begin
        n_sel_s = n_sel_s;
      end
    end
    count_next_s = count_r + CW'(disp_s) - CW'(n_sel_s);
  end

  // Entry storage: issue frees a slot, dispatch fills one, wakeup captures operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r   <= '0;
      rs1_rdy_r <= '0;
      rs2_rdy_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]      <= 6'd0;
        rs1_r[i]     <= 6'd0;
        rs2_r[i]     <= 6'd0;
        rs1_val_r[i] <= 32'd0;
        rs2_val_r[i] <= 32'd0;
        ctl_r[i]     <= 55'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_s[i]) begin
          valid_r[i] <= 1'b0;
        end else if (disp_s && free_idx_s == IW'(i)) begin
          valid_r[i]   <= 1'b1;
          rd_r[i]      <= iq.phys_rd;
          rs1_r[i]     <= iq.phys_rs1;
          rs2_r[i]     <= iq.phys_rs2;
          rs1_rdy_r[i] <= d1_s[32];
          rs2_rdy_r[i] <= d2_s[32];
          rs1_val_r[i] <= d1_s[31:0];
          rs2_val_r[i] <= d2_s[31:0];
          ctl_r[i]     <= {iq.funct3, iq.funct7, iq.opcode, iq.immediate, iq.ROB_entry_index};
        end else begin
          if (wake1_s[i]) begin
            rs1_rdy_r[i] <= 1'b1;
            rs1_val_r[i] <= m1_s[i][31:0];
          end
          if (wake2_s[i]) begin
            rs2_rdy_r[i] <= 1'b1;
            rs2_val_r[i] <= m2_s[i][31:0];
          end
        end
      end
    end
  end

  // Physical register ready table; a dispatch clear beats a same-cycle broadcast.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_tbl_r <= '1;
    end else begin
      for (int t = 1; t < 64; t++) begin
        if (disp_s && iq.phys_rd == 6'(t)) begin
          ready_tbl_r[t] <= 1'b0;
        end else if (iq.fwd_enable && (iq.fwd_rd_funct_unit0 == 6'(t) || iq.fwd_rd_funct_unit1 == 6'(t) ||
                                       iq.fwd_rd_funct_unit2 == 6'(t) || iq.fwd_rd_mem == 6'(t))) begin
          ready_tbl_r[t] <= 1'b1;
        end
      end
    end
  end

  // Registered issue packets; an idle unit drops its enable but keeps the old packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r    <= 3'b000;
      count_r <= '0;
      full_r  <= 1'b0;
      for (int f = 0; f < 3; f++) pkt_r[f] <= 139'd0;
    end else begin
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      for (int f = 0; f < 3; f++) begin
        en_r[f] <= sel_vld_s[f];
        if (sel_vld_s[f]) begin
          pkt_r[f] <= {2'b11, rd_r[sel_idx_s[f]], rs1_r[sel_idx_s[f]], rs1_val_r[sel_idx_s[f]],
                       rs2_r[sel_idx_s[f]], rs2_val_r[sel_idx_s[f]], ctl_r[sel_idx_s[f]]};
        end
      end
    end
  end

  assign iq.issued_funct_unit0 = pkt_r[0];
  assign iq.issued_funct_unit1 = pkt_r[1];
  assign iq.issued_funct_unit2 = pkt_r[2];
  assign iq.funct0_enable      = en_r[0];
  assign iq.funct1_enable      = en_r[1];
  assign iq.funct2_enable      = en_r[2];
  assign iq.issue_queue_full   = full_r;
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: expected packets are queued at dispatch
// and matched in order against packets the queue issues.
module tb_issue_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  issue_queue_if bus ();
  issue_queue #(.DEPTH(16)) dut (.clk(clk), .reset_n(reset_n), .iq(bus));

  always #5 clk = ~clk;

  logic [2:0]   en_w;
  logic [138:0] pkt_w [3];
  assign en_w     = {bus.funct2_enable, bus.funct1_enable, bus.funct0_enable};
  assign pkt_w[0] = bus.issued_funct_unit0;
  assign pkt_w[1] = bus.issued_funct_unit1;
  assign pkt_w[2] = bus.issued_funct_unit2;

  logic [140:0] exp_q [$];
  logic [140:0] got_q [$];

  function automatic logic [138:0] mk(input logic [5:0] rd, input logic [5:0] rs1, input logic [31:0] v1,
                                      input logic [5:0] rs2, input logic [31:0] v2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [6:0] op, input logic [31:0] imm,
                                      input logic [5:0] rob);
    return {2'b11, rd, rs1, v1, rs2, v2, f3, f7, op, imm, rob};
  endfunction

  task automatic idle();
    bus.write_enable       = 1'b0;
    bus.fwd_enable         = 1'b0;
    bus.fwd_rd_funct_unit0 = 6'd0;
    bus.fwd_rd_funct_unit1 = 6'd0;
    bus.fwd_rd_funct_unit2 = 6'd0;
    bus.fwd_rd_mem         = 6'd0;
  endtask

  task automatic dispatch(input logic [5:0] rd, input logic [5:0] rs1, input logic [31:0] v1,
                          input logic [5:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [5:0] rob, input logic [2:0] f3 = 3'b010,
                          input logic [6:0] f7 = 7'b0000000, input logic [6:0] op = 7'b0110011);
    bus.write_enable    = 1'b1;
    bus.phys_rd         = rd;
    bus.phys_rs1        = rs1;
    bus.phys_rs1_val    = v1;
    bus.phys_rs2        = rs2;
    bus.phys_rs2_val    = v2;
    bus.immediate       = imm;
    bus.ROB_entry_index = rob;
    bus.funct3          = f3;
    bus.funct7          = f7;
    bus.opcode          = op;
  endtask

  // Advance one clock and record every packet that became valid.
  task automatic tick();
    @(negedge clk);
    for (int f = 0; f < 3; f++) if (en_w[f]) got_q.push_back({2'(f), pkt_w[f]});
  endtask

  task automatic test_reset();
    idle();
    dispatch(6'd0, 6'd0, 32'd0, 6'd0, 32'd0, 32'd0, 6'd0);
    bus.write_enable           = 1'b0;
    bus.fwd_rd_val_funct_unit0 = 32'd0;
    bus.fwd_rd_val_funct_unit1 = 32'd0;
    bus.fwd_rd_val_funct_unit2 = 32'd0;
    bus.fwd_rd_val_mem         = 32'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL reset_en: got %b expected 000", en_w); else pass_cnt++;
    chk_cnt++; if (bus.issue_queue_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.issue_queue_full); else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      chk_cnt++;
      if (pkt_w[f] !== 139'd0) $display("FAIL reset_pkt%0d: got %h expected 0", f, pkt_w[f]); else pass_cnt++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_forward_dispatch();
    bus.fwd_enable = 1'b1;
    bus.fwd_rd_funct_unit0 = 6'd5; bus.fwd_rd_val_funct_unit0 = 32'hCAFEBABE;
    bus.fwd_rd_funct_unit1 = 6'd7; bus.fwd_rd_val_funct_unit1 = 32'hDEADBEEF;
    bus.fwd_rd_funct_unit2 = 6'd9; bus.fwd_rd_val_funct_unit2 = 32'hFFFFFFFF;
    dispatch(6'd10, 6'd5, 32'h11111111, 6'd5, 32'h22222222, 32'h12345678, 6'd20,
             3'b101, 7'b0101010, 7'b1100110);
    exp_q.push_back({2'd0, mk(6'd10, 6'd5, 32'hCAFEBABE, 6'd5, 32'hCAFEBABE, 3'b101, 7'b0101010,
                              7'b1100110, 32'h12345678, 6'd20)});
    tick();
    idle();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL fwd_not_yet: got %b expected 000", en_w); else pass_cnt++;
    tick();
    chk_cnt++; if (en_w !== 3'b001) $display("FAIL fwd_issue_en: got %b expected 001", en_w); else pass_cnt++;
    chk_cnt++;
    if (pkt_w[0][124:93] !== 32'hCAFEBABE) $display("FAIL fwd_rs1_val: got %h expected cafebabe", pkt_w[0][124:93]);
    else pass_cnt++;
    tick();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL fwd_one_cycle: got %b expected 000", en_w); else pass_cnt++;
  endtask

  task automatic test_wakeup();
    dispatch(6'd12, 6'd0, 32'hAAAAAAAA, 6'd0, 32'hBBBBBBBB, 32'd1, 6'd1);
    exp_q.push_back({2'd0, mk(6'd12, 6'd0, 32'd0, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011, 32'd1, 6'd1)});
    tick();
    dispatch(6'd13, 6'd12, 32'h00000BAD, 6'd0, 32'd3, 32'd2, 6'd2);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++; if (en_w !== 3'b000) $display("FAIL wake_waiting%0d: got %b expected 000", c, en_w); else pass_cnt++;
    end
    bus.fwd_enable = 1'b1;
    bus.fwd_rd_mem = 6'd12;
    bus.fwd_rd_val_mem = 32'h55;
    exp_q.push_back({2'd0, mk(6'd13, 6'd12, 32'h55, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011, 32'd2, 6'd2)});
    tick();
    idle();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL wake_edge: got %b expected 000", en_w); else pass_cnt++;
    tick();
    chk_cnt++; if (en_w !== 3'b001) $display("FAIL wake_issue: got %b expected 001", en_w); else pass_cnt++;
  endtask

  task automatic test_triple_issue();
    dispatch(6'd20, 6'd0, 32'd0, 6'd0, 32'd0, 32'd10, 6'd10);
    exp_q.push_back({2'd0, mk(6'd20, 6'd0, 32'd0, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011, 32'd10, 6'd10)});
    tick();
    idle();
    tick();
    for (int k = 0; k < 4; k++) begin
      dispatch(6'(21 + k), 6'd20, 32'h0BADF00D, 6'd0, 32'd9, 32'(100 + k), 6'(k));
      tick();
    end
    idle();
    bus.fwd_enable = 1'b1;
    bus.fwd_rd_funct_unit1 = 6'd20; bus.fwd_rd_val_funct_unit1 = 32'h77;
    bus.fwd_rd_mem         = 6'd20; bus.fwd_rd_val_mem         = 32'h99;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({2'(k % 3), mk(6'(21 + k), 6'd20, 32'h77, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011,
                                      32'(100 + k), 6'(k))});
    tick();
    idle();
    tick();
    chk_cnt++; if (en_w !== 3'b111) $display("FAIL triple_en: got %b expected 111", en_w); else pass_cnt++;
    tick();
    chk_cnt++; if (en_w !== 3'b001) $display("FAIL triple_fourth: got %b expected 001", en_w); else pass_cnt++;
    tick();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL triple_idle: got %b expected 000", en_w); else pass_cnt++;
  endtask

  task automatic test_full();
    dispatch(6'd30, 6'd0, 32'd0, 6'd0, 32'd0, 32'd50, 6'd50);
    exp_q.push_back({2'd0, mk(6'd30, 6'd0, 32'd0, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011, 32'd50, 6'd50)});
    tick();
    idle();
    tick();
    for (int k = 0; k < 16; k++) begin
      dispatch(6'(32 + k), 6'd30, 32'h0, 6'd0, 32'd0, 32'(200 + k), 6'(k));
      tick();
    end
    chk_cnt++; if (bus.issue_queue_full !== 1'b1) $display("FAIL full_set: got %b expected 1", bus.issue_queue_full); else pass_cnt++;
    dispatch(6'd0, 6'd0, 32'd0, 6'd0, 32'd0, 32'hDEAD, 6'd63);
    tick();
    idle();
    tick();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL full_drop: got %b expected 000", en_w); else pass_cnt++;
    chk_cnt++; if (bus.issue_queue_full !== 1'b1) $display("FAIL full_hold: got %b expected 1", bus.issue_queue_full); else pass_cnt++;
    bus.fwd_enable = 1'b1;
    bus.fwd_rd_funct_unit2 = 6'd30; bus.fwd_rd_val_funct_unit2 = 32'h1234;
    for (int k = 0; k < 16; k++)
      exp_q.push_back({2'(k % 3), mk(6'(32 + k), 6'd30, 32'h1234, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011,
                                      32'(200 + k), 6'(k))});
    tick();
    idle();
    chk_cnt++; if (bus.issue_queue_full !== 1'b1) $display("FAIL full_at_wake: got %b expected 1", bus.issue_queue_full); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.issue_queue_full !== 1'b0) $display("FAIL full_clear: got %b expected 0", bus.issue_queue_full); else pass_cnt++;
    chk_cnt++; if (en_w !== 3'b111) $display("FAIL full_issue: got %b expected 111", en_w); else pass_cnt++;
    repeat (5) tick();
    tick();
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL full_drained: got %b expected 000", en_w); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    dispatch(6'd40, 6'd0, 32'd0, 6'd0, 32'd0, 32'd7, 6'd7);
    exp_q.push_back({2'd0, mk(6'd40, 6'd0, 32'd0, 6'd0, 32'd0, 3'b010, 7'd0, 7'b0110011, 32'd7, 6'd7)});
    tick();
    dispatch(6'd41, 6'd40, 32'd0, 6'd0, 32'd0, 32'd8, 6'd8);
    tick();
    idle();
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if (en_w !== 3'b000) $display("FAIL async_en: got %b expected 000", en_w); else pass_cnt++;
    chk_cnt++; if (pkt_w[0] !== 139'd0) $display("FAIL async_pkt: got %h expected 0", pkt_w[0]); else pass_cnt++;
    #1 reset_n = 1'b1;
    bus.fwd_enable = 1'b1;
    bus.fwd_rd_funct_unit0 = 6'd40; bus.fwd_rd_val_funct_unit0 = 32'h4040;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_cnt++; if (en_w !== 3'b000) $display("FAIL async_lost%0d: got %b expected 000", c, en_w); else pass_cnt++;
    end
  endtask

  task automatic test_scoreboard();
    logic [140:0] e, g;
    chk_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL sb_count: got %0d packets expected %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk_cnt++;
      if (g !== e) $display("FAIL sb_packet: got fu%0d %h expected fu%0d %h", g[140:139], g[138:0], e[140:139], e[138:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_forward_dispatch();
    test_wakeup();
    test_triple_issue();
    test_full();
    test_async_reset();
    test_scoreboard();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
